// File: rtl/aer_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : aer_rr_arbiter
//  Purpose  : AER encoder for the hidden layer. Arbitrates N_CH spike
//             requests (round-robin or legacy fixed priority), packs
//             {channel, local address} into an event word and queues it in
//             a first-word-fall-through FIFO with valid/ready output.
//  Revision : 1.0 - initial release
// ============================================================================
module aer_rr_arbiter #(
    parameter int N_CH       = 16,
    parameter int CH_W       = $clog2(N_CH),
    parameter int LADDR_W    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int RR_MODE    = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_CH-1:0]                spikes_in,
    input  logic [N_CH*LADDR_W-1:0]        addr_in,
    output logic [N_CH-1:0]                acks_out,
    output logic                           aer_valid,
    input  logic                           aer_ready,
    output logic [CH_W+LADDR_W-1:0]        aer_addr,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           spike_out
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_EV_W  = CH_W + LADDR_W;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(FIFO_DEPTH);

    logic [c_EV_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [CH_W-1:0]    r_rr_ptr;

    logic               w_full;
    logic               w_grant_vld;
    logic [CH_W-1:0]    w_grant_ch;
    logic [LADDR_W-1:0] w_grant_addr;
    logic [N_CH-1:0]    w_acks;
    logic               w_push;
    logic               w_pop;

    // A pop in the full cycle does not free a slot for a push in that same
    // cycle: fullness is judged on the registered count only.
    assign w_full = (r_count == c_FULL_CNT);

    // Grant search: round-robin starts just after the last granted channel,
    // legacy mode always starts at channel 0.
    always_comb begin
        int w_idx;
        w_grant_vld  = 1'b0;
        w_grant_ch   = '0;
        w_grant_addr = '0;
        w_idx        = 0;
        if (!reset && !w_full) begin
            for (int k = 0; k < N_CH; k++) begin
                if (RR_MODE != 0) begin
                    w_idx = int'(r_rr_ptr) + k + 1;
                end else begin
                    w_idx = k;
                end
                if (w_idx >= N_CH) begin
                    w_idx = w_idx - N_CH;
                end
                if (!w_grant_vld && spikes_in[w_idx[CH_W-1:0]]) begin
                    w_grant_vld  = 1'b1;
                    w_grant_ch   = w_idx[CH_W-1:0];
                    w_grant_addr = addr_in[w_idx*LADDR_W +: LADDR_W];
                end
            end
        end
    end

    // One-hot acknowledge of the granted channel, zero when nothing granted.
    always_comb begin
        w_acks = '0;
        if (w_grant_vld) begin
            w_acks[w_grant_ch] = 1'b1;
        end
    end

    assign w_push = w_grant_vld;
    assign w_pop  = (r_count != '0) && aer_ready;

    // FIFO storage, pointers, occupancy and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= CH_W'(N_CH - 1);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_grant_ch, w_grant_addr};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
                r_rr_ptr        <= w_grant_ch;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign acks_out   = w_acks;
    assign aer_valid  = (r_count != '0);
    assign aer_addr   = r_mem[r_rd_ptr];
    assign fifo_count = r_count;
    assign spike_out  = |spikes_in;

endmodule
`default_nettype wire

// File: tb/tb_aer_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aer_rr_arbiter
//  Purpose  : Self-checking bench for aer_rr_arbiter, compared against a
//             queue-based behavioural model of the encoder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_aer_rr_arbiter;

    localparam int N_CH  = 16;
    localparam int LW    = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] spikes_in;
    logic [63:0] addr_in;
    logic        aer_ready;

    logic [15:0] acks_out;
    logic        aer_valid;
    logic [7:0]  aer_addr;
    logic [2:0]  fifo_count;
    logic        spike_out;

    logic [15:0] fp_acks;
    logic        fp_valid;
    logic [7:0]  fp_addr;
    logic [2:0]  fp_count;
    logic        fp_spike;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: event queue and last granted channel.
    logic [7:0] m_q[$];
    int         m_rr = N_CH - 1;

    aer_rr_arbiter #(.N_CH(N_CH), .CH_W(4), .LADDR_W(LW), .FIFO_DEPTH(DEPTH), .RR_MODE(1)) dut (
        .clk(clk), .reset(reset), .spikes_in(spikes_in), .addr_in(addr_in),
        .acks_out(acks_out), .aer_valid(aer_valid), .aer_ready(aer_ready),
        .aer_addr(aer_addr), .fifo_count(fifo_count), .spike_out(spike_out));

    aer_rr_arbiter #(.N_CH(N_CH), .CH_W(4), .LADDR_W(LW), .FIFO_DEPTH(DEPTH), .RR_MODE(0)) dut_fp (
        .clk(clk), .reset(reset), .spikes_in(spikes_in), .addr_in(addr_in),
        .acks_out(fp_acks), .aer_valid(fp_valid), .aer_ready(aer_ready),
        .aer_addr(fp_addr), .fifo_count(fp_count), .spike_out(fp_spike));

    always #5 clk = ~clk;

    // Channel the encoder should grant now, or -1.
    function automatic int model_grant();
        if (reset || m_q.size() >= DEPTH) return -1;
        for (int k = 1; k <= N_CH; k++) begin
            int c;
            c = (m_rr + k) % N_CH;
            if (spikes_in[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [15:0] model_ack();
        int g;
        g = model_grant();
        if (g < 0) return 16'h0000;
        return 16'h0001 << g;
    endfunction

    // Advance the model by one rising edge using the current inputs.
    task automatic model_clock();
        int g;
        logic [3:0] ch;
        g = model_grant();
        if (reset) begin
            m_q.delete();
            m_rr = N_CH - 1;
        end else begin
            if (m_q.size() > 0 && aer_ready) void'(m_q.pop_front());
            if (g >= 0) begin
                ch = g[3:0];
                m_q.push_back({ch, addr_in[g*LW +: LW]});
                m_rr = g;
            end
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; spikes_in = 16'hFFFF; aer_ready = 1'b0; addr_in = {$urandom, $urandom};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (acks_out !== 16'h0000) begin n_fail++; $display("FAIL reset_acks: got %h expected 0000", acks_out); end
            if (i == 1) begin
                n_checks++;
                if (aer_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", aer_valid); end
                n_checks++;
                if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
            end
            model_clock();
            next_edge();
        end
    endtask

    task automatic test_single();
        reset = 1'b0; spikes_in = 16'h0020; aer_ready = 1'b1;
        addr_in = 64'h0; addr_in[5*LW +: LW] = 4'hA;
        @(negedge clk);
        n_checks++;
        if (acks_out !== 16'h0020) begin n_fail++; $display("FAIL single_ack: got %h expected 0020", acks_out); end
        n_checks++;
        if (spike_out !== 1'b1) begin n_fail++; $display("FAIL single_spike_out: got %b expected 1", spike_out); end
        model_clock();
        next_edge();
        spikes_in = 16'h0000;
        @(negedge clk);
        n_checks++;
        if (aer_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", aer_valid); end
        n_checks++;
        if (aer_addr !== 8'h5A) begin n_fail++; $display("FAIL single_addr: got %h expected 5a", aer_addr); end
        n_checks++;
        if (spike_out !== 1'b0) begin n_fail++; $display("FAIL single_spike_idle: got %b expected 0", spike_out); end
        model_clock();
        next_edge();
    endtask

    task automatic test_fairness();
        reset = 1'b1; spikes_in = 16'h0000; aer_ready = 1'b1;
        model_clock();
        next_edge();
        reset = 1'b0; spikes_in = 16'h8001; addr_in = {$urandom, $urandom};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (acks_out !== ((i % 2 == 0) ? 16'h0001 : 16'h8000)) begin
                n_fail++; $display("FAIL rr_alternate[%0d]: got %h expected %h", i, acks_out, (i % 2 == 0) ? 16'h0001 : 16'h8000);
            end
            n_checks++;
            if (fp_acks !== 16'h0001) begin n_fail++; $display("FAIL fixed_prio[%0d]: got %h expected 0001", i, fp_acks); end
            n_checks++;
            if (aer_valid && aer_addr !== m_q[0]) begin n_fail++; $display("FAIL rr_head[%0d]: got %h expected %h", i, aer_addr, m_q[0]); end
            model_clock();
            next_edge();
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] pend;
        int          got[$];
        reset = 1'b1; spikes_in = 16'h0000; aer_ready = 1'b0;
        model_clock();
        next_edge();
        reset = 1'b0; pend = 16'h007E; addr_in = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            int g;
            spikes_in = pend;
            @(negedge clk);
            g = model_grant();
            n_checks++;
            if (acks_out !== model_ack()) begin n_fail++; $display("FAIL bp_ack[%0d]: got %h expected %h", i, acks_out, model_ack()); end
            if (i >= 4) begin
                n_checks++;
                if (acks_out !== 16'h0000 || fifo_count !== 3'd4) begin
                    n_fail++; $display("FAIL bp_full[%0d]: got ack %h count %0d expected ack 0000 count 4", i, acks_out, fifo_count);
                end
            end
            model_clock();
            if (g >= 0) pend[g] = 1'b0;
            next_edge();
        end
        aer_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int g;
            spikes_in = pend;
            @(negedge clk);
            g = model_grant();
            if (i == 0) begin
                n_checks++;
                if (acks_out !== 16'h0000) begin n_fail++; $display("FAIL bp_pop_in_full: got %h expected 0000", acks_out); end
            end
            n_checks++;
            if (acks_out !== model_ack()) begin n_fail++; $display("FAIL drain_ack[%0d]: got %h expected %h", i, acks_out, model_ack()); end
            n_checks++;
            if (fifo_count !== 3'(m_q.size())) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, fifo_count, m_q.size()); end
            if (m_q.size() > 0) begin
                n_checks++;
                if (aer_addr !== m_q[0]) begin n_fail++; $display("FAIL drain_addr[%0d]: got %h expected %h", i, aer_addr, m_q[0]); end
            end
            if (aer_valid) got.push_back(int'(aer_addr[7:4]));
            model_clock();
            if (g >= 0) pend[g] = 1'b0;
            next_edge();
        end
        n_checks++;
        if (got.size() != 6) begin
            n_fail++; $display("FAIL drain_total: got %0d events expected 6", got.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_checks++;
                if (got[k] != k + 1) begin n_fail++; $display("FAIL drain_order[%0d]: got ch %0d expected ch %0d", k, got[k], k + 1); end
            end
        end
    endtask

    task automatic test_push_pop();
        reset = 1'b1; spikes_in = 16'h0000; aer_ready = 1'b0;
        model_clock();
        next_edge();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            addr_in = {$urandom, $urandom};
            if (i < 2) begin
                aer_ready = 1'b0; spikes_in = 16'h0004 << i;
            end else begin
                aer_ready = 1'b1; spikes_in = 16'h0001 << $urandom_range(0, 15);
            end
            @(negedge clk);
            n_checks++;
            if (acks_out !== model_ack()) begin n_fail++; $display("FAIL pp_ack[%0d]: got %h expected %h", i, acks_out, model_ack()); end
            if (i >= 2) begin
                n_checks++;
                if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL pp_count[%0d]: got %0d expected 2", i, fifo_count); end
            end
            if (m_q.size() > 0) begin
                n_checks++;
                if (aer_addr !== m_q[0]) begin n_fail++; $display("FAIL pp_addr[%0d]: got %h expected %h", i, aer_addr, m_q[0]); end
            end
            model_clock();
            next_edge();
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; spikes_in = 16'h0000; aer_ready = 1'b0;
        model_clock();
        next_edge();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            spikes_in = 16'h0002 << i;
            model_clock();
            next_edge();
        end
        spikes_in = 16'h0000;
        @(negedge clk);
        n_checks++;
        if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL mid_count_before: got %0d expected 3", fifo_count); end
        reset = 1'b1; spikes_in = 16'h0001;
        #1;
        n_checks++;
        if (acks_out !== 16'h0000) begin n_fail++; $display("FAIL mid_ack_in_reset: got %h expected 0000", acks_out); end
        model_clock();
        next_edge();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fifo_count !== 3'd0 || aer_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_flushed: got count %0d valid %b expected count 0 valid 0", fifo_count, aer_valid);
        end
        n_checks++;
        if (acks_out !== 16'h0001) begin n_fail++; $display("FAIL mid_reack: got %h expected 0001", acks_out); end
        model_clock();
        next_edge();
        spikes_in = 16'h0000;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 59) == 0);
            spikes_in = 16'($urandom & $urandom & $urandom);
            addr_in   = {$urandom, $urandom};
            aer_ready = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n_checks++;
            if (acks_out !== model_ack()) begin n_fail++; $display("FAIL rnd_ack[%0d]: got %h expected %h", i, acks_out, model_ack()); end
            n_checks++;
            if (fifo_count !== 3'(m_q.size()) || aer_valid !== (m_q.size() > 0)) begin
                n_fail++; $display("FAIL rnd_state[%0d]: got count %0d valid %b expected count %0d", i, fifo_count, aer_valid, m_q.size());
            end
            if (m_q.size() > 0) begin
                n_checks++;
                if (aer_addr !== m_q[0]) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", i, aer_addr, m_q[0]); end
            end
            n_checks++;
            if (spike_out !== (spikes_in != 16'h0000)) begin n_fail++; $display("FAIL rnd_spike_out[%0d]: got %b expected %b", i, spike_out, spikes_in != 16'h0000); end
            model_clock();
            next_edge();
        end
    endtask

    initial begin
        reset = 1'b1; spikes_in = 16'h0000; addr_in = 64'h0; aer_ready = 1'b0;
        next_edge();
        test_reset();
        test_single();
        test_fairness();
        test_back_pressure();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
